// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared definitions for the instruction-fetch stage: the NOP
//            encoding held in the output register after reset, the fetch FSM
//            state encoding and the default reset PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // RISC-V "addi x0, x0, 0", the canonical NOP
    localparam logic [31:0] c_NOP              = 32'h0000_0013;
    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pipe_reg
// Purpose  : Valid/ready output register between fetch and decode. Holds
//            {instr, pc, valid}. Priority: flush > capture > drain > hold.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_flush         - drop any pending instruction
//            i_capture       - load i_instr/i_pc and mark valid
//            i_instr, i_pc   - instruction and its byte address
//            i_ready         - downstream accepts the output this cycle
//            o_valid, o_instr, o_pc - registered output to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pipe_reg
    import fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [31:0]           i_pc,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [31:0]           o_pc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [31:0]           r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= DATA_WIDTH'(c_NOP);
            r_pc    <= 32'h0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            // Accepted with nothing new behind it: the slot empties
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : fetch_pipe_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction
//            memory word address (zero-wait, combinational read data) and
//            captures each instruction with its PC into a valid/ready
//            register toward decode. Handles redirect, halt and back-pressure.
// Ports    : clock, reset        - clock, synchronous active-high reset
//            redirect_valid/_pc  - load a new PC (highest priority)
//            halt_req            - stop issuing fetches
//            imem_addr/imem_rdata- instruction memory interface
//            out_valid/out_ready/out_instr/out_pc - output to decode
//            halted              - FSM is in S_HALT
//            misalign_fault      - sticky misaligned-redirect flag
//                                  (only with FETCH_MISALIGN_TRAP_EN)
// Config   : `define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
//            instead of silently clearing redirect_pc[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] RESET_PC   = c_DEFAULT_RESET_PC
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc,
    output logic                  halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_fault
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_stateNext;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcNext;
    logic         w_load;
    logic         w_capture;
    logic         w_flush;
    logic         w_redirMisaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic         r_fault;
    assign w_redirMisaligned = (redirect_pc[1:0] != 2'b00);
`else
    // Low bits are dropped on load; nothing else looks at them
    logic         w_unusedLowBits;
    assign w_unusedLowBits   = &{1'b0, redirect_pc[1:0]};
    assign w_redirMisaligned = 1'b0;
`endif

    assign w_load = !out_valid || out_ready;

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_capture   = 1'b0;
        w_flush     = 1'b0;
        if (redirect_valid) begin
            w_flush = 1'b1;
            if (w_redirMisaligned) begin
                // PC is left untouched so the faulting context is preserved
                w_stateNext = S_HALT;
            end else begin
                w_pcNext    = {redirect_pc[31:2], 2'b00};
                w_stateNext = S_RUN;
            end
        end else begin
            unique case (r_state)
                S_BOOT: w_stateNext = S_RUN;
                S_RUN: begin
                    if (halt_req) begin
                        w_stateNext = S_HALT;
                    end else if (w_load) begin
                        w_capture = 1'b1;
                        w_pcNext  = r_pc + 32'd4;
                    end
                end
                S_HALT: w_stateNext = S_HALT;
                default: w_stateNext = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (redirect_valid && w_redirMisaligned) begin
            r_fault <= 1'b1;
        end
    end
    assign misalign_fault = r_fault;
`endif

    // Word address wraps naturally by truncation
    assign imem_addr = r_pc[ADDR_WIDTH+1:2];
    assign halted    = (r_state == S_HALT);

    fetch_pipe_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pipe_reg (
        .clk       (clock),
        .rst       (reset),
        .i_flush   (w_flush),
        .i_capture (w_capture),
        .i_instr   (imem_rdata),
        .i_pc      (r_pc),
        .i_ready   (out_ready),
        .o_valid   (out_valid),
        .o_instr   (out_instr),
        .o_pc      (out_pc)
    );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed scenarios followed
//            by randomized back-pressure/halt/redirect/reset traffic, checked
//            each cycle against a behavioural model of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int AW = 6;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          halted;
    logic          fault;

    logic [31:0]   memw [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // Behavioural model of the stage
    logic [31:0] mPc, mI, mP;
    bit          mBoot, mHalt, mV, mFault;

    always #5 clock = ~clock;

    assign imem_rdata = memw[imem_addr];

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .RESET_PC   (RPC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (fault)
`endif
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign fault = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven
    task automatic modelStep();
        bit ld;
        if (reset) begin
            mPc = RPC; mBoot = 1; mHalt = 0; mV = 0;
            mI = 32'h13; mP = 0; mFault = 0;
        end else begin
            ld = !mV || out_ready;
            if (redirect_valid) begin
                mV = 0; mBoot = 0;
                if (TRAP && redirect_pc[1:0] != 2'b00) begin
                    mFault = 1; mHalt = 1;
                end else begin
                    mPc = redirect_pc & ~32'h3; mHalt = 0;
                end
            end else if (mBoot) begin
                mBoot = 0;
            end else if (mHalt || halt_req) begin
                mHalt = 1;
                if (out_ready) mV = 0;
            end else if (ld) begin
                mI = memw[mPc[AW+1:2]];
                mP = mPc; mV = 1; mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic cyc();
        modelStep();
        @(posedge clock);
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, mV});
        chk("halted", {31'b0, halted}, {31'b0, mHalt});
        chk("imem_addr", {26'b0, imem_addr}, {26'b0, mPc[AW+1:2]});
        if (TRAP) chk("misalign_fault", {31'b0, fault}, {31'b0, mFault});
        if (mV) begin
            chk("out_pc", out_pc, mP);
            chk("out_instr", out_instr, mI);
        end
    endtask

    task automatic redirectTo(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) memw[i] = i;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        halt_req = 1'b0; out_ready = 1'b1;

        // Reset state
        cyc(); cyc();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);

        // Boot cycle then free-run
        reset = 1'b0;
        cyc();
        chk("boot_novalid", {31'b0, out_valid}, 32'h0);
        cyc(); chk("run_pc0", out_pc, 32'h0);
        cyc(); chk("run_instr1", out_instr, 32'h1);
        cyc(); chk("run_pc8", out_pc, 32'h8);

        // Stall three cycles at out_pc=8
        out_ready = 1'b0;
        repeat (3) cyc();
        chk("stall_pc", out_pc, 32'h8);
        chk("stall_instr", out_instr, 32'h2);
        out_ready = 1'b1;
        cyc(); chk("release_pc12", out_pc, 32'hC);

        // Redirect under back-pressure flushes the pending instruction
        out_ready = 1'b0;
        cyc();
        redirectTo(32'h40);
        chk("redir_flush", {31'b0, out_valid}, 32'h0);
        cyc();
        chk("redir_pc40", out_pc, 32'h40);
        chk("redir_instr16", out_instr, 32'd16);
        out_ready = 1'b1;

        // Halt at out_pc=0x10, resume via redirect with halt_req still high
        redirectTo(32'h8);
        repeat (3) cyc();
        chk("pre_halt_pc", out_pc, 32'h10);
        halt_req = 1'b1;
        repeat (3) cyc();
        chk("halted_hi", {31'b0, halted}, 32'h1);
        chk("halted_noval", {31'b0, out_valid}, 32'h0);
        redirectTo(32'h20);
        halt_req = 1'b0;
        cyc();
        chk("resume_pc20", out_pc, 32'h20);

        // Address wrap 63 -> 0
        redirectTo(32'hF8);
        cyc(); cyc();
        chk("wrap_addr0", {26'b0, imem_addr}, 32'h0);
        cyc();
        chk("wrap_pc100", out_pc, 32'h100);
        chk("wrap_instr0", out_instr, 32'h0);

        // Reset mid-stall
        out_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_addr", {26'b0, imem_addr}, {26'b0, RPC[AW+1:2]});
        reset = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Misaligned redirect
        redirectTo(32'h22);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_halted", {31'b0, halted}, 32'h1);
        chk("mis_addr_hold", {26'b0, imem_addr}, 32'h2);
        cyc();
        redirectTo(32'h24);
        cyc();
        chk("mis_resume_pc", out_pc, 32'h24);
        chk("mis_sticky", {31'b0, fault}, 32'h1);
`else
        cyc();
        chk("align_pc20", out_pc, 32'h20);
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            halt_req       = ($urandom_range(0, 24) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
            reset          = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
